// File: rtl/alu_issue_ctrl_if.sv
// ALU operand/result bus between the issue controller (master) and the
// combinational ALU (slave).
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  modport master (output alu_a, alu_b, alu_op, input alu_out, alu_zero);
  modport slave  (input alu_a, alu_b, alu_op, output alu_out, alu_zero);
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: accepts one register-format instruction,
// drives the combinational ALU from an 8x16 register file and writes back.
//   state  | meaning
//   S_IDLE | ready for an instruction; external reg-file writes allowed
//   S_READ | operands read, ALU inputs loaded (illegal op skips to S_WB)
//   S_EXEC | ALU inputs held; result captured at end of cycle
//   S_WB   | done pulse; result and zero flag committed for legal ops
module alu_issue_ctrl #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_instr_valid,
  input  logic [15:0]      i_instr,
  output logic             o_instr_ready,
  input  logic             i_wr_en,
  input  logic [2:0]       i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  alu_issue_ctrl_if.master alu,
  output logic             o_done,
  output logic             o_err,
  output logic             o_zero_flag,
  input  logic [2:0]       i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [12:0]      r_instr;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_op;
  logic [WIDTH-1:0] r_res;
  logic             r_res_zero;
  logic             r_done;
  logic             r_err;
  logic             r_zero_flag;

  logic             w_fire;
  logic             w_legal;
  logic             w_inv_b;
  logic [3:0]       w_op;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs;
  logic [2:0]       w_rt;
  logic [WIDTH-1:0] w_rs_val;
  logic [WIDTH-1:0] w_rt_val;

  assign w_fire   = i_instr_valid && (r_state == S_IDLE);
  assign w_op     = r_instr[12:9];
  assign w_rd     = r_instr[8:6];
  assign w_rs     = r_instr[5:3];
  assign w_rt     = r_instr[2:0];
  assign w_rs_val = (w_rs == 3'd0) ? '0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 3'd0) ? '0 : r_regs[w_rt];
  // The ALU only adds op[0] as carry-in, so b is inverted here to form a - b.
  assign w_inv_b  = (w_op == 4'd1) || (w_op == 4'd7);

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd12, 4'd14: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fire) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = w_legal ? S_EXEC : S_WB;
      S_EXEC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_res       <= '0;
      r_res_zero  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_zero_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == S_WB);
      r_err   <= (w_state_nxt == S_WB) && !w_legal;
      if (w_fire) r_instr <= i_instr[15:3];
      if (r_state == S_READ && w_legal) begin
        r_alu_a  <= w_rs_val;
        r_alu_b  <= w_inv_b ? ~w_rt_val : w_rt_val;
        r_alu_op <= w_op;
      end
      if (r_state == S_EXEC) begin
        r_res      <= alu.alu_out;
        r_res_zero <= alu.alu_zero;
      end
      if (r_state == S_WB && w_legal) r_zero_flag <= r_res_zero;
    end
  end

  // External preload only in IDLE; writeback only in WB, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (r_state == S_IDLE && i_wr_en && i_wr_addr != 3'd0) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end else if (r_state == S_WB && w_legal && w_rd != 3'd0) begin
      r_regs[w_rd] <= r_res;
    end
  end

  assign o_instr_ready = (r_state == S_IDLE);
  assign alu.alu_a     = r_alu_a;
  assign alu.alu_b     = r_alu_b;
  assign alu.alu_op    = r_alu_op;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_zero_flag   = r_zero_flag;
  assign o_dbg_data    = (i_dbg_addr == 3'd0) ? '0 : r_regs[i_dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'h0000;
  logic [2:0]  dbg_addr = 3'd0;
  logic        instr_ready, done, err, zero_flag;
  logic [15:0] dbg_data;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  alu_issue_ctrl_if #(.WIDTH(16)) aif();

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Combinational ALU: adds op[0] as carry-in; slt returns sign of a+b+1.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    logic [15:0] s;
    s = a + b + {15'd0, op[0]};
    case (op)
      4'd0, 4'd1: return s;
      4'd2:  return a & b;
      4'd4:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return {15'd0, s[15]};
      4'd8:  return a >> b[3:0];
      4'd12: return a << b[3:0];
      4'd14: return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  assign aif.alu_out  = alu_f(aif.alu_a, aif.alu_b, aif.alu_op);
  assign aif.alu_zero = (aif.alu_out == 16'h0000);

  alu_issue_ctrl #(.NREGS(8), .WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_instr_valid(instr_valid), .i_instr(instr), .o_instr_ready(instr_ready),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .alu(aif),
    .o_done(done), .o_err(err), .o_zero_flag(zero_flag),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural semantics of each opcode.
  function automatic logic [15:0] sem(input logic [3:0] op, input logic [15:0] x,
                                      input logic [15:0] y);
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd4:  return x | y;
      4'd6:  return x ^ y;
      4'd7:  return ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      4'd8:  return x >> y[3:0];
      4'd12: return x << y[3:0];
      4'd14: return ~x;
      default: return 16'h0000;
    endcase
  endfunction

  // Reference model: k counts cycles since the accepting edge (0 = none in flight).
  logic [15:0] m_regs [8];
  logic [15:0] m_a, m_b, va, vb, p_res;
  logic [3:0]  m_op, p_op;
  logic [2:0]  p_rd, p_rs, p_rt;
  logic        m_zf, p_legal;
  bit          m_live = 1'b0;
  int          k = 0;
  int          p_final = 0;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0000;
      m_a = '0; m_b = '0; m_op = '0; m_zf = 1'b0; k = 0; m_live = 1'b1;
    end else if (k == 0) begin
      if (wr_en && wr_addr != 3'd0) m_regs[wr_addr] = wr_data;
      if (instr_valid) begin
        p_op = instr[15:12]; p_rd = instr[11:9]; p_rs = instr[8:6]; p_rt = instr[5:3];
        p_legal = (p_op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd12, 4'd14});
        p_final = p_legal ? 3 : 2;
        k = 1;
      end
    end else begin
      if (k == 1 && p_legal) begin
        va = m_regs[p_rs]; vb = m_regs[p_rt];
        m_a = va;
        m_b = (p_op == 4'd1 || p_op == 4'd7) ? ~vb : vb;
        m_op = p_op;
        p_res = sem(p_op, va, vb);
      end
      if (k == p_final) begin
        if (p_legal) begin
          if (p_rd != 3'd0) m_regs[p_rd] = p_res;
          m_zf = (p_res == 16'h0000);
        end
        k = 0;
      end else begin
        k = k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("ready", instr_ready, k == 0);
      chk("done", done, k != 0 && k == p_final);
      chk("err", err, k != 0 && k == p_final && !p_legal);
      chk("zero_flag", zero_flag, m_zf);
      chk("alu_a", aif.alu_a, m_a);
      chk("alu_b", aif.alu_b, m_b);
      chk("alu_op", aif.alu_op, m_op);
      chk("dbg_data", dbg_data, m_regs[dbg_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  logic [15:0] e_a, e_b;
  logic [3:0]  e_op;
  logic        e_err;
  int          lat;

  // lat = cycle of the done pulse counted from the accepting edge (-1 on timeout).
  task automatic issue(input logic [15:0] ins, input bit exec_wr);
    int n;
    n = 0;
    instr = ins; instr_valid = 1'b1;
    while (!instr_ready && n < 10) begin tick(); n++; end
    if (!instr_ready) chk("handshake_timeout", 0, 1);
    tick();
    instr_valid = 1'b0; wr_en = 1'b0;
    lat = 0;
    while (!done && lat < 8) begin
      if (lat == 1) begin
        e_a = aif.alu_a; e_b = aif.alu_b; e_op = aif.alu_op;
        if (exec_wr) begin wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; end
      end
      tick();
      wr_en = 1'b0;
      lat++;
    end
    e_err = err;
    lat = done ? lat + 1 : -1;
    tick();
  endtask

  task automatic peek(input logic [2:0] a, input logic [15:0] exp, input string nm);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  logic [15:0] bb [4] = '{16'h0650, 16'h2850, 16'h4A50, 16'hCC50};
  int hs [4];

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_alu_a", aif.alu_a, 0);
    chk("rst_zf", zero_flag, 0);

    preload(3'd1, 16'h0005); preload(3'd2, 16'h0003);
    issue(16'h0250, 1'b0);
    chk("add_lat", lat, 3);
    chk("add_exec_a", e_a, 16'h0005);
    chk("add_exec_b", e_b, 16'h0003);
    chk("add_exec_op", e_op, 4'd0);
    peek(3'd1, 16'h0008, "add_r1");
    chk("add_zf", zero_flag, 0);

    preload(3'd1, 16'h0005); preload(3'd2, 16'h0005);
    issue(16'h1650, 1'b0);
    chk("sub_exec_b", e_b, 16'hFFFA);
    peek(3'd3, 16'h0000, "sub_r3");
    chk("sub_zf", zero_flag, 1);

    preload(3'd1, 16'h0002); preload(3'd2, 16'h0007);
    issue(16'h7850, 1'b0);
    chk("slt_exec_b", e_b, 16'hFFF8);
    peek(3'd4, 16'h0001, "slt_r4");
    issue(16'h7888, 1'b0);
    chk("slt_swap_b", e_b, 16'hFFFD);
    peek(3'd4, 16'h0000, "slt_swap_r4");

    issue(16'h3250, 1'b0);
    chk("ill_lat", lat, 2);
    chk("ill_err", e_err, 1);
    chk("ill_alu_a", aif.alu_a, 16'h0007);
    chk("ill_alu_b", aif.alu_b, 16'hFFFD);
    chk("ill_alu_op", aif.alu_op, 4'd7);
    chk("ill_zf", zero_flag, 1);
    peek(3'd1, 16'h0002, "ill_r1");

    issue(16'h0050, 1'b0);
    peek(3'd0, 16'h0000, "r0_zero");

    issue(16'h0C50, 1'b1);
    peek(3'd5, 16'h0000, "exec_wr_ignored");
    peek(3'd6, 16'h0009, "add_r6");

    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0010;
    issue(16'h0E50, 1'b0);
    chk("same_edge_a", e_a, 16'h0010);
    peek(3'd7, 16'h0017, "same_edge_r7");

    instr = 16'h0250; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", instr_ready, 1);
    chk("abort_done", done, 0);
    for (int i = 0; i < 8; i++) peek(i[2:0], 16'h0000, "abort_regs");
    for (int i = 0; i < 3; i++) begin tick(); chk("abort_no_done", done, 0); end

    preload(3'd1, 16'h0001); preload(3'd2, 16'h0002);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      instr = bb[i]; instr_valid = 1'b1;
      while (!instr_ready && n < 10) begin tick(); n++; end
      hs[i] = cyc;
      tick();
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 1; i < 4; i++) chk("b2b_interval", hs[i] - hs[i-1], 4);
    peek(3'd3, 16'h0003, "b2b_r3");
    peek(3'd4, 16'h0000, "b2b_r4");
    peek(3'd5, 16'h0003, "b2b_r5");
    peek(3'd6, 16'h0004, "b2b_r6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle execute-stage controller on the driving side of the 16-bit ALU interface.
- Accepts one 16-bit register-format instruction via a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives a, b and op to the combinational ALU, then captures the ALU's out and zero back into the destination register and a zero flag.
- Sits between instruction fetch and the ALU in the 16-bit CPU.

Parameters:
- NREGS, 8, number of architectural registers; addressed by 3 bits; r0 reads as zero.
- WIDTH, 16, datapath width; must match the ALU.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction present
- instr  input  16  [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] ignored
- instr_ready  output  1  controller can accept an instruction
- wr_en  input  1  external register-file write (preload)
- wr_addr  input  3  external write address
- wr_data  input  16  external write data
- alu_a  output  16  ALU operand a
- alu_b  output  16  ALU operand b
- alu_op  output  4  ALU opcode
- alu_out  input  16  ALU result
- alu_zero  input  1  ALU zero flag
- done  output  1  one-cycle pulse when an instruction retires
- err  output  1  one-cycle pulse with done for an illegal opcode
- zero_flag  output  1  zero of the last legal retired instruction
- dbg_addr  input  3  debug read address
- dbg_data  output  16  combinational read of the register file (r0 reads 0)

Behaviour:
- States: IDLE, READ, EXEC, WB. Reset forces IDLE.
- Reset values: all registers 0; alu_a, alu_b, alu_op, done, err and zero_flag are 0.
- instr_ready = (state==IDLE). Handshake fires when instr_valid and instr_ready are both high; the instruction is latched on that edge.
- IDLE -> READ on handshake. Otherwise remain in IDLE.
- READ:
  - Latch rs and rt values; r0 yields 0.
  - Set alu_op from the instruction.
  - alu_a = rs value.
  - alu_b = ~rt for op 1 (sub) and op 7 (slt); otherwise rt. The ALU adds op[0] as carry-in without inverting b, so this inversion completes a - b.
  - Legal ops: 0 add, 1 sub, 2 and, 4 or, 6 xor, 7 slt, 8 shr, 12 shl, 14 not.
  - Illegal op: alu outputs unchanged, go directly to WB with an error marked.
  - Legal op: go to EXEC.
- EXEC: alu_a, alu_b and alu_op are held stable. alu_out and alu_zero are sampled at the end of this cycle. Go to WB.
- WB:
  - done = 1 for one cycle.
  - Legal op: write the captured result to rd (writes to r0 are dropped); zero_flag <= captured alu_zero.
  - Illegal op: err = 1; no register write; zero_flag unchanged.
  - Return to IDLE.
- Latency: handshake at edge N gives done high during cycle N+3. Throughput is one instruction per 4 cycles. done and err are registered.
- alu outputs keep their last values after WB until the next READ; they are not cleared.
- External write: honoured only in IDLE (wr_en ignored in other states). wr_en and a handshake on the same edge are both honoured; the operand read in READ sees the new value.
- An rd equal to rs or rt is allowed. Operands are latched in READ, so writeback does not affect them.
- rst asserted in any state aborts the instruction: no writeback, no done, all registers cleared, IDLE on the next cycle.
- No combinational path from alu_out to any output except through registers.

Test Plan:
- Preload r1=0x0005 and r2=0x0003; instr 0x0250 (add r1,r1,r2 rd=1). Required: alu_a=5, alu_b=3 and op=0 during EXEC; done 3 cycles after handshake; r1=0x0008; zero_flag=0.
- r1=5, r2=5; sub r3=r1-r2 (instr 0x1650). Required: alu_b=0xFFFA; r3=0x0000; zero_flag=1.
- r1=0x0002, r2=0x0007; slt r4 (op 7). Required: alu_b=0xFFF8; r4=0x0001. Then swap operands. Required: r4=0x0000.
- Illegal op 3 (instr 0x3250). Required: done and err both high in the same cycle 2 cycles after handshake (WB follows READ directly); no register changes; zero_flag unchanged; alu_* unchanged.
- Write to rd=0 (add r0,r1,r2). Required: dbg_data at dbg_addr 0 stays 0. wr_en to r5 while in EXEC is ignored. wr_en plus handshake in the same IDLE cycle: the new value is used as an operand.
- Assert rst during EXEC. Required: no done pulse; all registers 0; instr_ready=1 on the cycle after rst deasserts; back-to-back instructions then retire every 4 cycles.
